res_bcd_converter: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3, one bit per clock) directly downstream of the divider.

---
 rtl/res_bcd_if.sv | 26 ++
 rtl/res_bcd_converter.sv | 152 +++++++++++++++
 tb/tb_res_bcd_converter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/res_bcd_if.sv
// Handshake/data bundle between the divider side and the BCD converter.
// master drives en/bin_in/ready_in and reads bcd/blank/ovf/busy/done/valid.
interface res_bcd_if #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
);
  logic                  en;
  logic [WIDTH-1:0]      bin_in;
  logic                  ready_in;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;
  logic                  ovf;
  logic                  busy;
  logic                  done;
  logic                  valid;

  modport master (
    output en, bin_in, ready_in,
    input  bcd, blank, ovf, busy, done, valid
  );

  modport slave (
    input  en, bin_in, ready_in,
    output bcd, blank, ovf, busy, done, valid
  );
endinterface

// File: rtl/res_bcd_converter.sv
// Shift-add-3 binary to packed BCD, one bit per clock, started on a rising
// edge of ready_in. Ports: clk, rst_n, bus_if (slave: en/bin_in/ready_in in;
// bcd/blank/ovf/busy/done/valid out).
module res_bcd_converter #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  res_bcd_if.slave    bus_if
);
  localparam int DW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic              ready_q;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [DW-1:0]     dig_q, dig_d;
  logic              acc_ovf_q, acc_ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;

  logic              start;
  logic [DW-1:0]     adj;
  logic [DIGITS-1:0] blk;
  logic              zero;

  assign start = bus_if.ready_in & ~ready_q;

  always_comb begin
    adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // blank[i]: every digit from i upward is zero; digit 0 always shown.
  always_comb begin
    zero = 1'b1;
    blk  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero   = zero & (dig_q[4*i +: 4] == 4'd0);
      blk[i] = zero & ~acc_ovf_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    dig_d     = dig_q;
    acc_ovf_d = acc_ovf_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus_if.en && start) begin
          state_d   = SHIFT;
          shreg_d   = bus_if.bin_in;
          dig_d     = '0;
          acc_ovf_d = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (!bus_if.en) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          dig_d     = {adj[DW-2:0], shreg_q[WIDTH-1]};
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          // A carry out of the top digit means the value needs more digits.
          acc_ovf_d = acc_ovf_q | adj[DW-1];
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (bus_if.en) begin
          bcd_d   = acc_ovf_q ? {DIGITS{4'h9}} : dig_q;
          ovf_d   = acc_ovf_q;
          blank_d = blk;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      shreg_q   <= '0;
      dig_q     <= '0;
      acc_ovf_q <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      blank_q   <= ~DIGITS'(1);
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= bus_if.ready_in;
      shreg_q   <= shreg_d;
      dig_q     <= dig_d;
      acc_ovf_q <= acc_ovf_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  assign bus_if.bcd   = bcd_q;
  assign bus_if.blank = blank_q;
  assign bus_if.ovf   = ovf_q;
  assign bus_if.busy  = busy_q;
  assign bus_if.done  = done_q;
  assign bus_if.valid = valid_q;
endmodule

// File: tb/tb_res_bcd_converter.sv
// Scoreboard bench for res_bcd_converter: a 4-digit and a 3-digit instance
// share one stimulus stream; a decimal model predicts each result.
module tb_res_bcd_converter;
  logic clk;
  logic rst_n;

  res_bcd_if #(.WIDTH(12), .DIGITS(4)) i4 ();
  res_bcd_if #(.WIDTH(12), .DIGITS(3)) i3 ();

  assign i3.en       = i4.en;
  assign i3.bin_in   = i4.bin_in;
  assign i3.ready_in = i4.ready_in;

  res_bcd_converter #(.WIDTH(12), .DIGITS(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (i4.slave)
  );

  res_bcd_converter #(.WIDTH(12), .DIGITS(3)) dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (i3.slave)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t last4, last3;
  int   tests = 0;
  int   fails = 0;
  int   dn4 = 0;
  int   dn3 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Decimal digits by division; blank[i] means value < 10^i.
  function automatic exp_t model(input int v, input int d);
    exp_t e;
    int   p;
    int   lim;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    e.bcd   = '0;
    e.blank = '0;
    e.ovf   = (v >= lim);
    p = 1;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = e.ovf ? 4'h9 : 4'((v / p) % 10);
      e.blank[i]      = (i > 0) && !e.ovf && (v < p);
      p = p * 10;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && i4.done) begin
      dn4++;
      if (q4.size() == 0) begin
        chk("unexpected_done4", 1, 0);
      end else begin
        last4 = q4.pop_front();
        chk("bcd4", 32'(i4.bcd), 32'(last4.bcd));
        chk("blank4", 32'(i4.blank), 32'(last4.blank));
        chk("ovf4", 32'(i4.ovf), 32'(last4.ovf));
      end
    end
    if (rst_n && i3.done) begin
      dn3++;
      if (q3.size() == 0) begin
        chk("unexpected_done3", 1, 0);
      end else begin
        last3 = q3.pop_front();
        chk("bcd3", 32'(i3.bcd), 32'(last3.bcd[11:0]));
        chk("blank3", 32'(i3.blank), 32'(last3.blank[2:0]));
        chk("ovf3", 32'(i3.ovf), 32'(last3.ovf));
      end
    end
  end

  task automatic chk_rst();
    chk("rst_bcd4", 32'(i4.bcd), 0);
    chk("rst_blank4", 32'(i4.blank), 32'hE);
    chk("rst_bcd3", 32'(i3.bcd), 0);
    chk("rst_blank3", 32'(i3.blank), 32'h6);
    chk("rst_flags4", {i4.ovf, i4.busy, i4.done, i4.valid}, 0);
    chk("rst_flags3", {i3.ovf, i3.busy, i3.done, i3.valid}, 0);
  endtask

  task automatic clr();
    q4.delete();
    q3.delete();
    last4 = model(0, 4);
    last3 = model(0, 3);
  endtask

  task automatic conv(input int v, input int g);
    int cyc;
    int bz;
    @(negedge clk);
    i4.bin_in   = 12'(v);
    i4.ready_in = 1'b1;
    q4.push_back(model(v, 4));
    q3.push_back(model(v, 3));
    @(negedge clk);
    i4.ready_in = 1'b0;
    i4.bin_in   = 12'($urandom);
    cyc = 0;
    bz  = 0;
    while (!i4.done && cyc < 40) begin
      if (i4.busy) bz++;
      if (g != 0 && cyc == g) begin
        i4.ready_in = 1'b1;
        i4.bin_in   = 12'($urandom);
      end else begin
        i4.ready_in = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    i4.ready_in = 1'b0;
    chk("latency", cyc, 13);
    chk("busy_len", bz, 13);
    chk("valid", 32'(i4.valid), 1);
    @(negedge clk);
    chk("done_pulse", 32'(i4.done), 0);
  endtask

  initial begin
    int d4;
    int d3;
    int v;
    rst_n       = 1'b0;
    i4.en       = 1'b1;
    i4.bin_in   = '0;
    i4.ready_in = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk_rst();
    rst_n = 1'b1;
    @(negedge clk);

    conv(1234, 0);
    conv(7, 0);
    conv(0, 0);
    conv(4095, 0);
    conv(999, 0);
    conv(1000, 0);
    conv(100, 4);
    conv(10, 12);

    // ready_in held high with bin_in churning: one conversion only
    d4 = dn4;
    d3 = dn3;
    @(negedge clk);
    v = int'($urandom_range(0, 4095));
    i4.bin_in   = 12'(v);
    i4.ready_in = 1'b1;
    q4.push_back(model(v, 4));
    q3.push_back(model(v, 3));
    repeat (50) begin
      @(negedge clk);
      i4.bin_in = 12'($urandom);
    end
    i4.ready_in = 1'b0;
    @(negedge clk);
    chk("held_done4", dn4 - d4, 1);
    chk("held_done3", dn3 - d3, 1);

    // reset in mid-conversion
    @(negedge clk);
    i4.bin_in   = 12'd1234;
    i4.ready_in = 1'b1;
    @(negedge clk);
    i4.ready_in = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rst();
    clr();
    @(negedge clk);
    rst_n = 1'b1;
    conv(42, 0);

    // en low during SHIFT aborts without touching results
    d4 = dn4;
    d3 = dn3;
    @(negedge clk);
    i4.bin_in   = 12'd999;
    i4.ready_in = 1'b1;
    @(negedge clk);
    i4.ready_in = 1'b0;
    repeat (3) @(negedge clk);
    i4.en = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_done4", dn4 - d4, 0);
    chk("abort_done3", dn3 - d3, 0);
    chk("abort_busy", {i4.busy, i3.busy}, 0);
    chk("abort_bcd4", 32'(i4.bcd), 32'(last4.bcd));
    chk("abort_bcd3", 32'(i3.bcd), 32'(last3.bcd[11:0]));
    i4.en = 1'b1;

    for (int k = 0; k < 20; k++) begin
      v = int'($urandom_range(0, 4095));
      conv(v, ($urandom % 3 == 0) ? int'($urandom_range(1, 12)) : 0);
    end

    repeat (5) @(negedge clk);
    chk("q4_empty", q4.size(), 0);
    chk("q3_empty", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
